win_pattern_detector: RTL and testbench
=======================================

WIN_PATTERN_DETECTOR -- requirements
Module: win_pattern_detector

Interface
REQ-001 SHALL have parameter WIDTH, 32, screen vector width in bits (legal range 2..64).
REQ-002 SHALL have parameter STABLE_CYCLES, 4, consecutive matching samples required to declare a win (legal range 1..255).
REQ-003 SHALL have parameter BUZZ_CYCLES, 1000, buzz pulse length in clock cycles (legal range 1..2^20).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  detection armed when high.
REQ-007 SHALL have port clear  input  1  single-cycle request to drop a latched win.
REQ-008 SHALL have port screen_values  input  WIDTH  current board state.
REQ-009 SHALL have port win  output  1  high while a win is declared (states BUZZ and LATCHED).
REQ-010 SHALL have port buzz  output  1  buzzer drive, high only in state BUZZ.
REQ-011 SHALL have port win_code  output  2  pattern of the declared win: 00 all-zeros, 01 all-ones, 10 alternating with LSB=1 (...0101), 11 alternating with LSB=0 (...1010).

Function
REQ-012 SHALL classify screen_values each cycle into exactly one of the four patterns or no-match (the patterns are mutually exclusive for WIDTH>=2).
REQ-013 SHALL implement FSM states IDLE, QUALIFY, BUZZ, LATCHED, plus a stability counter (8 bits) and a buzz counter (20 bits).
REQ-014 IDLE: on an enabled edge with a match, SHALL load stab_cnt=1 and cand_code=the match code, then go to BUZZ if STABLE_CYCLES=1, else QUALIFY.
REQ-015 QUALIFY: on the same code, SHALL increment stab_cnt; when the incremented value equals STABLE_CYCLES, SHALL go to BUZZ, load win_code=cand_code and set buzz_cnt=0.
REQ-016 QUALIFY: on a different match code, SHALL restart with stab_cnt=1 and the new cand_code; on no-match, SHALL return to IDLE.
REQ-017 Latency: a pattern held stably across STABLE_CYCLES consecutive edges SHALL raise win and buzz in the cycle immediately after the last of those edges.
REQ-018 BUZZ: SHALL increment buzz_cnt each cycle, and after BUZZ_CYCLES cycles of buzz high SHALL go to LATCHED.
REQ-019 LATCHED: SHALL hold win=1, buzz=0 and win_code unchanged, ignoring screen_values and enable, until clear.
REQ-020 enable low in IDLE or QUALIFY SHALL force IDLE with counters cleared; enable SHALL NOT affect BUZZ or LATCHED.
REQ-021 clear in BUZZ or LATCHED SHALL go to IDLE next edge (an aborted buzz ends immediately); clear in IDLE or QUALIFY SHALL have no effect.
REQ-022 clear SHALL take priority over a simultaneous match; matching SHALL resume on the following edge.
REQ-023 win_code SHALL read 00 whenever win=0.

Reset
REQ-024 With reset high at an edge: state=IDLE, win=0, buzz=0, win_code=00, all counters 0, overriding enable, clear and screen_values, including mid-BUZZ or mid-QUALIFY.
REQ-025 The first evaluation SHALL occur on the first edge with reset low.

Configuration
REQ-026 With macro WIN_COUNTER_EN defined: SHALL add output win_count (8 bits, reset 0), incremented on each entry to BUZZ and saturating at 255.
REQ-027 Without WIN_COUNTER_EN: the win_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package win_pkg SHALL hold the FSM state enum, the four 2-bit pattern-code constants, and the counter width constants.
REQ-029 Pattern classification SHALL be the combinational sub-module win_pattern_match (parameter WIDTH; outputs match, code); all state stays in win_pattern_detector.

Verification (WIDTH=8, STABLE_CYCLES=3, BUZZ_CYCLES=5)
REQ-030 8'hFF held 3 edges with enable=1 -> win=1, buzz=1, win_code=01 the next cycle; buzz high exactly 5 cycles; then win stays 1 with buzz=0.
REQ-031 8'h55 for 2 edges, then 8'hAA for 3 edges -> qualification restarts; win_code=11 declared after the 5th edge, not before.
REQ-032 8'h00 for 2 edges, then 8'h13 -> no win; state IDLE.
REQ-033 Reset asserted on the 3rd buzz cycle -> next cycle win=0, buzz=0, win_code=00; a new pattern needs 3 fresh edges.
REQ-034 clear in LATCHED while 8'h00 is held -> win=0 next cycle; win re-declared (code 00) 3 edges after the clear edge.
REQ-035 With WIN_COUNTER_EN: 256 wins -> win_count=255; with enable=0 and 8'hFF held -> no win and no increment.

Source files
------------

// File: rtl/win_pkg.sv
// Shared types and constants for the win pattern detector.
package win_pkg;

    // Counter widths
    localparam int STAB_W = 8;   // stability counter
    localparam int BUZZ_W = 20;  // buzz duration counter
    localparam int WCNT_W = 8;   // optional win counter

    // Pattern codes reported on win_code
    localparam logic [1:0] CODE_ZEROS = 2'b00;  // all zeros
    localparam logic [1:0] CODE_ONES  = 2'b01;  // all ones
    localparam logic [1:0] CODE_ALT1  = 2'b10;  // ...0101 (LSB = 1)
    localparam logic [1:0] CODE_ALT0  = 2'b11;  // ...1010 (LSB = 0)

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUALIFY,
        ST_BUZZ,
        ST_LATCHED
    } win_state_e;

endpackage

// File: rtl/win_pattern_match.sv
// Combinational classifier: maps the screen vector onto one of four winning
// patterns, or reports no match. The patterns are disjoint for WIDTH >= 2.
module win_pattern_match
    import win_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] screen_values,
    output logic             match,
    output logic [1:0]       code
);

    // Alternating reference with bit 0 set (...0101); its inverse is ...1010
    logic [WIDTH-1:0] alt_lsb1;

    for (genvar g = 0; g < WIDTH; g++) begin : g_alt
        assign alt_lsb1[g] = ((g % 2) == 0);
    end

    // Priority order is irrelevant since at most one pattern can hit
    always_comb begin
        match = 1'b1;
        code  = CODE_ZEROS;
        if (screen_values == '0) begin
            code = CODE_ZEROS;
        end else if (screen_values == '1) begin
            code = CODE_ONES;
        end else if (screen_values == alt_lsb1) begin
            code = CODE_ALT1;
        end else if (screen_values == ~alt_lsb1) begin
            code = CODE_ALT0;
        end else begin
            match = 1'b0;
        end
    end

endmodule

// File: rtl/win_pattern_detector.sv
// Win pattern detector: declares a win once the screen shows the same winning
// pattern for STABLE_CYCLES consecutive enabled edges, buzzes for BUZZ_CYCLES
// cycles, then latches the win until cleared.
// Optional feature: define WIN_COUNTER_EN to add the saturating win_count output.
module win_pattern_detector
    import win_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int STABLE_CYCLES = 4,
    parameter int BUZZ_CYCLES   = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] screen_values,
    output logic             win,
    output logic             buzz,
    output logic [1:0]       win_code
`ifdef WIN_COUNTER_EN
    ,
    output logic [7:0]       win_count
`endif
);

    localparam logic [STAB_W-1:0] STAB_TARGET = STAB_W'(STABLE_CYCLES);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST   = BUZZ_W'(BUZZ_CYCLES - 1);

    win_state_e        state_q, state_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [BUZZ_W-1:0] buzz_cnt_q, buzz_cnt_d;
    logic [1:0]        cand_q, cand_d;
    logic [1:0]        code_q, code_d;

    logic              match;
    logic [1:0]        match_code;
    logic [STAB_W-1:0] stab_inc;

    win_pattern_match #(
        .WIDTH(WIDTH)
    ) u_match (
        .screen_values(screen_values),
        .match        (match),
        .code         (match_code)
    );

    assign stab_inc = stab_cnt_q + STAB_W'(1);

    // Next-state logic: qualification, buzz timing, latch and clear handling
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        buzz_cnt_d = buzz_cnt_q;
        cand_d     = cand_q;
        code_d     = code_q;
        case (state_q)
            ST_IDLE: begin
                stab_cnt_d = '0;
                buzz_cnt_d = '0;
                if (enable && match) begin
                    stab_cnt_d = STAB_W'(1);
                    cand_d     = match_code;
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_BUZZ;
                        code_d  = match_code;
                    end else begin
                        state_d = ST_QUALIFY;
                    end
                end
            end
            ST_QUALIFY: begin
                if (!enable || !match) begin
                    state_d    = ST_IDLE;
                    stab_cnt_d = '0;
                    cand_d     = CODE_ZEROS;
                end else if (match_code == cand_q) begin
                    stab_cnt_d = stab_inc;
                    if (stab_inc == STAB_TARGET) begin
                        state_d    = ST_BUZZ;
                        code_d     = cand_q;
                        buzz_cnt_d = '0;
                    end
                end else begin
                    // A different pattern restarts qualification from one
                    stab_cnt_d = STAB_W'(1);
                    cand_d     = match_code;
                end
            end
            ST_BUZZ: begin
                if (clear) begin
                    state_d    = ST_IDLE;
                    stab_cnt_d = '0;
                    buzz_cnt_d = '0;
                    code_d     = CODE_ZEROS;
                end else begin
                    buzz_cnt_d = buzz_cnt_q + BUZZ_W'(1);
                    if (buzz_cnt_q == BUZZ_LAST) begin
                        state_d = ST_LATCHED;
                    end
                end
            end
            ST_LATCHED: begin
                if (clear) begin
                    state_d    = ST_IDLE;
                    stab_cnt_d = '0;
                    buzz_cnt_d = '0;
                    code_d     = CODE_ZEROS;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            stab_cnt_q <= '0;
            buzz_cnt_q <= '0;
            cand_q     <= CODE_ZEROS;
            code_q     <= CODE_ZEROS;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            buzz_cnt_q <= buzz_cnt_d;
            cand_q     <= cand_d;
            code_q     <= code_d;
        end
    end

    // Outputs decode straight from the registered state
    always_comb begin
        win      = (state_q == ST_BUZZ) || (state_q == ST_LATCHED);
        buzz     = (state_q == ST_BUZZ);
        win_code = win ? code_q : CODE_ZEROS;
    end

`ifdef WIN_COUNTER_EN
    logic [WCNT_W-1:0] win_count_q;

    // Count every entry into BUZZ, saturating at the top value
    always_ff @(posedge clk) begin
        if (reset) begin
            win_count_q <= '0;
        end else if ((state_d == ST_BUZZ) && (state_q != ST_BUZZ)
                     && (win_count_q != '1)) begin
            win_count_q <= win_count_q + WCNT_W'(1);
        end
    end

    assign win_count = win_count_q;
`endif

endmodule

// File: tb/tb_win_pattern_detector.sv
// Bench for win_pattern_detector (WIDTH=8, STABLE_CYCLES=3, BUZZ_CYCLES=5).
// A run-length model predicts outputs each cycle; directed sequences add
// literal expectations at the interesting points.
module tb_win_pattern_detector;

    localparam int W    = 8;
    localparam int STAB = 3;
    localparam int BUZ  = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] screen_values = '0;
    logic         win, buzz;
    logic [1:0]   win_code;
`ifdef WIN_COUNTER_EN
    logic [7:0]   win_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    win_pattern_detector #(
        .WIDTH        (W),
        .STABLE_CYCLES(STAB),
        .BUZZ_CYCLES  (BUZ)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clear        (clear),
        .screen_values(screen_values),
        .win          (win),
        .buzz         (buzz),
        .win_code     (win_code)
`ifdef WIN_COUNTER_EN
        ,
        .win_count    (win_count)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int cls(input logic [W-1:0] s);
        if (s == 8'h00) return 0;
        if (s == 8'hFF) return 1;
        if (s == 8'h55) return 2;
        if (s == 8'hAA) return 3;
        return -1;
    endfunction

    bit  m_win = 0;
    int  m_code = 0;
    int  m_buzz_left = 0;
    int  m_run = 0;
    int  m_run_code = 0;
    int  m_cnt = 0;

    always @(posedge clk) begin
        int c;
        c = cls(screen_values);
        if (reset) begin
            m_win = 0; m_code = 0; m_buzz_left = 0; m_run = 0; m_run_code = 0; m_cnt = 0;
        end else if (m_win) begin
            if (clear) begin
                m_win = 0;
                m_run = 0;
            end else if (m_buzz_left > 0) begin
                m_buzz_left--;
            end
        end else if (!enable || c < 0) begin
            m_run = 0;
        end else begin
            if (m_run > 0 && c == m_run_code) m_run++;
            else begin
                m_run = 1;
                m_run_code = c;
            end
            if (m_run == STAB) begin
                m_win = 1;
                m_code = m_run_code;
                m_buzz_left = BUZ;
                m_run = 0;
                if (m_cnt < 255) m_cnt++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        chk("model.win", {31'd0, win}, m_win ? 32'd1 : 32'd0);
        chk("model.buzz", {31'd0, buzz}, (m_win && m_buzz_left > 0) ? 32'd1 : 32'd0);
        chk("model.code", {30'd0, win_code}, m_win ? 32'(m_code) : 32'd0);
`ifdef WIN_COUNTER_EN
        chk("model.count", {24'd0, win_count}, 32'(m_cnt));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic e, input logic c, input logic [W-1:0] s);
        reset = r; enable = e; clear = c; screen_values = s;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string nm, input logic w, input logic b, input logic [1:0] cd);
        chk({nm, ".win"}, {31'd0, win}, {31'd0, w});
        chk({nm, ".buzz"}, {31'd0, buzz}, {31'd0, b});
        chk({nm, ".code"}, {30'd0, win_code}, {30'd0, cd});
    endtask

    initial begin
        // Reset
        step(1, 1, 0, 8'hFF);
        step(1, 1, 1, 8'hFF);
        lit("reset", 0, 0, 2'b00);

        // All ones held: win after 3rd edge, buzz for 5 cycles, then latched
        step(0, 1, 0, 8'hFF); lit("ones.e1", 0, 0, 2'b00);
        step(0, 1, 0, 8'hFF); lit("ones.e2", 0, 0, 2'b00);
        step(0, 1, 0, 8'hFF); lit("ones.e3", 1, 1, 2'b01);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'hFF); lit("ones.buzz", 1, 1, 2'b01);
        end
        step(0, 1, 0, 8'hFF); lit("ones.latched", 1, 0, 2'b01);
        step(0, 0, 0, 8'h00); lit("latched.ignore", 1, 0, 2'b01);
        step(0, 1, 0, 8'h13); lit("latched.hold", 1, 0, 2'b01);
        // Clear beats a simultaneous match; matching resumes next edge
        step(0, 1, 1, 8'hFF); lit("clear.prio", 0, 0, 2'b00);
        step(0, 1, 0, 8'hFF); lit("resume.e1", 0, 0, 2'b00);
        step(0, 1, 0, 8'hFF); lit("resume.e2", 0, 0, 2'b00);
        step(0, 1, 0, 8'hFF); lit("resume.e3", 1, 1, 2'b01);
        step(0, 1, 1, 8'h13); lit("clear.buzz", 0, 0, 2'b00);

        // 55 twice then AA three times: restart, code 11 after 5th edge
        step(0, 1, 0, 8'h55);
        step(0, 1, 0, 8'h55); lit("alt.e2", 0, 0, 2'b00);
        step(0, 1, 0, 8'hAA);
        step(0, 1, 0, 8'hAA); lit("alt.e4", 0, 0, 2'b00);
        step(0, 1, 0, 8'hAA); lit("alt.e5", 1, 1, 2'b11);
        step(0, 1, 1, 8'h13);
        // 55 alone gives code 10
        step(0, 1, 0, 8'h55);
        step(0, 1, 0, 8'h55);
        step(0, 1, 0, 8'h55); lit("alt1", 1, 1, 2'b10);
        step(0, 1, 1, 8'h13);

        // 00 twice, then a non-pattern: back to idle, needs 3 fresh edges
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h13); lit("nomatch", 0, 0, 2'b00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00); lit("nomatch.fresh2", 0, 0, 2'b00);
        step(0, 1, 0, 8'h00); lit("nomatch.fresh3", 1, 1, 2'b00);
        step(0, 1, 1, 8'h13);

        // Reset on the 3rd buzz cycle
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'hFF); lit("rst.buzz1", 1, 1, 2'b01);
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'hFF); lit("rst.buzz3", 1, 1, 2'b01);
        step(1, 1, 0, 8'hFF); lit("rst.mid", 0, 0, 2'b00);
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'hFF); lit("rst.fresh2", 0, 0, 2'b00);
        step(0, 1, 0, 8'hFF); lit("rst.fresh3", 1, 1, 2'b01);

        // Reach LATCHED on zeros, clear while zeros held, re-declared 3 edges later
        step(0, 1, 1, 8'h00);
        for (int i = 0; i < 3 + BUZ; i++) step(0, 1, 0, 8'h00);
        lit("zeros.latched", 1, 0, 2'b00);
        step(0, 1, 1, 8'h00); lit("zeros.clear", 0, 0, 2'b00);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00); lit("zeros.e2", 0, 0, 2'b00);
        step(0, 1, 0, 8'h00); lit("zeros.e3", 1, 1, 2'b00);
        step(0, 1, 1, 8'h13);

        // Enable drop during qualification restarts it
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'hFF);
        step(0, 0, 0, 8'hFF);
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'hFF); lit("en.drop", 0, 0, 2'b00);
        step(0, 1, 0, 8'hFF); lit("en.win", 1, 1, 2'b01);
        // Enable low does not stop a running buzz
        step(0, 0, 0, 8'h13); lit("en.buzz", 1, 1, 2'b01);
        step(0, 1, 1, 8'h13);

        // Pseudo-random mix, checked by the model each cycle
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] s;
            case ($urandom_range(0, 5))
                0: s = 8'h00;
                1: s = 8'hFF;
                2: s = 8'h55;
                3: s = 8'hAA;
                4: s = 8'h13;
                default: s = 8'($urandom);
            endcase
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 5) == 0), s);
        end

`ifdef WIN_COUNTER_EN
        // 256 wins saturate the counter at 255; disabled screen adds nothing
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 256; i++) begin
            step(0, 1, 0, 8'hFF);
            step(0, 1, 0, 8'hFF);
            step(0, 1, 0, 8'hFF);
            step(0, 1, 1, 8'h13);
        end
        chk("count.sat", {24'd0, win_count}, 32'd255);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 8'hFF);
        chk("count.hold", {24'd0, win_count}, 32'd255);
        lit("count.nowin", 0, 0, 2'b00);
`endif

        step(0, 0, 0, 8'h13);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
